// File: rtl/hal_pkg.sv
// -----------------------------------------------------------------------------
// hal_pkg -- shared constants for the HAL sequencer slice.
//   op_e      : instruction opcodes carried in RI[15:12]
//   state_e   : sequencer FSM state encoding
//   ULA_*     : ALU operand-select codes (ula_a / ula_b)
//   CP_SRC_*  : program-counter write source (fonte_cp)
//   WB_SRC_*  : register-file write-back source (fonte_wb)
// -----------------------------------------------------------------------------
package hal_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_AND  = 4'h2,
      OP_OR   = 4'h3,
      OP_XOR  = 4'h4,
      OP_SLL  = 4'h5,
      OP_SRL  = 4'h6,
      OP_ADDI = 4'h7,
      OP_MUL  = 4'h8,
      OP_MFHI = 4'h9,
      OP_MFLO = 4'hA,
      OP_BEQZ = 4'hB,
      OP_JMP  = 4'hC,
      OP_HALT = 4'hF
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MULW   = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_e;

   localparam logic       ULA_A_CP   = 1'b0;
   localparam logic       ULA_A_A    = 1'b1;
   localparam logic [1:0] ULA_B_B    = 2'd0;
   localparam logic [1:0] ULA_B_ONE  = 2'd1;
   localparam logic [1:0] ULA_B_IMM  = 2'd2;

   localparam logic [1:0] CP_SRC_ALU = 2'd0;
   localparam logic [1:0] CP_SRC_JMP = 2'd2;

   localparam logic [1:0] WB_SRC_ALU = 2'd0;
   localparam logic [1:0] WB_SRC_HI  = 2'd1;
   localparam logic [1:0] WB_SRC_LO  = 2'd2;

   // Register-to-register ALU ops and ADDI occupy opcodes 0..7.
   function automatic logic is_alu_op(input logic [OP_W-1:0] op);
      return (op <= OP_ADDI);
   endfunction

endpackage

// File: rtl/hal_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// hal_seq_ctrl_if -- sequencer <-> datapath signal bundle.
//   master : sequencer side (reads RI/flags, drives strobes and mux selects)
//   slave  : datapath side
// Signals: ri_valid, op_code[3:0], zero, mul_done (to sequencer);
//          fetch_req, ula_op[3:0], ula_a, ula_b[1:0], fonte_cp[1:0],
//          fonte_wb[1:0], rf_we, cp_we, mul_start, hilo_we, busy, err
//          (from sequencer).
// -----------------------------------------------------------------------------
interface hal_seq_ctrl_if;
   import hal_pkg::*;

   logic            ri_valid;
   logic [OP_W-1:0] op_code;
   logic            zero;
   logic            mul_done;

   logic            fetch_req;
   logic [3:0]      ula_op;
   logic            ula_a;
   logic [1:0]      ula_b;
   logic [1:0]      fonte_cp;
   logic [1:0]      fonte_wb;
   logic            rf_we;
   logic            cp_we;
   logic            mul_start;
   logic            hilo_we;
   logic            busy;
   logic            err;

   modport master (
      input  ri_valid, op_code, zero, mul_done,
      output fetch_req, ula_op, ula_a, ula_b, fonte_cp, fonte_wb,
             rf_we, cp_we, mul_start, hilo_we, busy, err
   );

   modport slave (
      output ri_valid, op_code, zero, mul_done,
      input  fetch_req, ula_op, ula_a, ula_b, fonte_cp, fonte_wb,
             rf_we, cp_we, mul_start, hilo_we, busy, err
   );

endinterface

// File: rtl/hal_timeout_cnt.sv
// -----------------------------------------------------------------------------
// hal_timeout_cnt -- down-counting watchdog.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (takes priority over enable)
//   load_val  : cycles-1 to allow before expiry
//   enable    : count down while high
//   expire    : high during the enabled cycle in which the count is zero,
//               i.e. the (load_val+1)-th enabled cycle after a load
// -----------------------------------------------------------------------------
module hal_timeout_cnt #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             enable,
   output logic             expire
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (enable && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign expire = enable && (cnt_q == '0);

endmodule

// File: rtl/hal_seq_ctrl.sv
// -----------------------------------------------------------------------------
// hal_seq_ctrl -- multi-cycle instruction sequencer.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : hal_seq_ctrl_if.master (RI handshake, datapath flags, strobes,
//           mux selects, busy, sticky err)
// Parameter MUL_TIMEOUT: MULW cycles allowed before the watchdog halts.
//
// Flow: IDLE -> FETCH -> DECODE -> EXEC -> [MULW] -> WB -> FETCH, with HALT
// as a terminal state left only through reset. All outputs are decoded from
// the current state, so an asserted reset silences them immediately.
// -----------------------------------------------------------------------------
module hal_seq_ctrl
   import hal_pkg::*;
#(
   parameter int MUL_TIMEOUT = 32
) (
   input  logic           clk,
   input  logic           rst,
   hal_seq_ctrl_if.master bus
);

   localparam int              TMR_W    = $clog2(MUL_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MUL_TIMEOUT - 1);

   state_e          state_q, state_d;
   logic [OP_W-1:0] op_q;
   logic            zero_q;
   logic            err_q;
   logic            set_err;
   logic            tmr_load;
   logic            tmr_en;
   logic            tmr_expire;

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         // Opcode is frozen at the end of DECODE; RI may change afterwards.
         if (state_q == S_DECODE) op_q   <= bus.op_code;
         // BEQZ decides on the flag as seen during EXEC.
         if (state_q == S_EXEC)   zero_q <= bus.zero;
         if (set_err)             err_q  <= 1'b1;
      end
   end

   hal_timeout_cnt #(
      .WIDTH (TMR_W)
   ) u_mul_wd (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (TMR_LOAD),
      .enable   (tmr_en),
      .expire   (tmr_expire)
   );

   assign bus.err = err_q;

   // NOTE: every signal written here gets a default first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      set_err       = 1'b0;
      tmr_load      = 1'b0;
      tmr_en        = 1'b0;
      bus.fetch_req = 1'b0;
      bus.ula_op    = OP_ADD;
      bus.ula_a     = ULA_A_CP;
      bus.ula_b     = ULA_B_B;
      bus.fonte_cp  = CP_SRC_ALU;
      bus.fonte_wb  = WB_SRC_ALU;
      bus.rf_we     = 1'b0;
      bus.cp_we     = 1'b0;
      bus.mul_start = 1'b0;
      bus.hilo_we   = 1'b0;
      bus.busy      = (state_q != S_IDLE) && (state_q != S_HALT);

      case (state_q)
         S_IDLE: state_d = S_FETCH;

         S_FETCH: begin
            bus.fetch_req = 1'b1;
            if (bus.ri_valid) state_d = S_DECODE;
         end

         S_DECODE: state_d = S_EXEC;

         S_EXEC: begin
            case (op_q)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
                  bus.ula_op = op_q;
                  bus.ula_a  = ULA_A_A;
                  bus.ula_b  = ULA_B_B;
                  state_d    = S_WB;
               end
               OP_ADDI: begin
                  bus.ula_op = op_q;
                  bus.ula_a  = ULA_A_A;
                  bus.ula_b  = ULA_B_IMM;
                  state_d    = S_WB;
               end
               OP_MUL: begin
                  bus.mul_start = 1'b1;
                  tmr_load      = 1'b1;
                  state_d       = S_MULW;
               end
               OP_MFHI, OP_MFLO, OP_BEQZ, OP_JMP: state_d = S_WB;
               OP_HALT: state_d = S_HALT;
               default: begin
                  // Illegal opcode: flag it, then only the CP+1 write in WB.
                  set_err = 1'b1;
                  state_d = S_WB;
               end
            endcase
         end

         S_MULW: begin
            tmr_en = 1'b1;
            // mul_done wins over expiry in the watchdog's final cycle.
            if (bus.mul_done) begin
               bus.hilo_we = 1'b1;
               state_d     = S_WB;
            end else if (tmr_expire) begin
               set_err = 1'b1;
               state_d = S_HALT;
            end
         end

         S_WB: begin
            // rf_we and cp_we share this cycle: the register file takes the
            // datapath's ALU result register while the ALU itself forms CP+1.
            bus.cp_we = 1'b1;
            if ((op_q == OP_JMP) || ((op_q == OP_BEQZ) && zero_q)) begin
               bus.fonte_cp = CP_SRC_JMP;
            end else begin
               bus.ula_a    = ULA_A_CP;
               bus.ula_b    = ULA_B_ONE;
               bus.ula_op   = OP_ADD;
               bus.fonte_cp = CP_SRC_ALU;
            end
            if (is_alu_op(op_q)) begin
               bus.rf_we    = 1'b1;
               bus.fonte_wb = WB_SRC_ALU;
            end else if (op_q == OP_MFHI) begin
               bus.rf_we    = 1'b1;
               bus.fonte_wb = WB_SRC_HI;
            end else if (op_q == OP_MFLO) begin
               bus.rf_we    = 1'b1;
               bus.fonte_wb = WB_SRC_LO;
            end
            state_d = S_FETCH;
         end

         S_HALT: state_d = S_HALT;

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_hal_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hal_seq_ctrl -- self-checking bench for hal_seq_ctrl.
// Each instruction is predicted as a set of strobe events (which strobe, in
// which cycle counted from the FETCH cycle that accepted RI, with which mux
// selects) plus the cycle at which the sequencer is back in FETCH or halted.
// -----------------------------------------------------------------------------
module tb_hal_seq_ctrl;

   localparam int TO = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   m_err   = 1'b0;

   hal_seq_ctrl_if bus ();

   hal_seq_ctrl #(
      .MUL_TIMEOUT (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   task automatic check(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int outs();
      return int'({bus.fetch_req, bus.busy, bus.err, bus.rf_we, bus.cp_we,
                   bus.mul_start, bus.hilo_we, bus.ula_op, bus.ula_a,
                   bus.ula_b, bus.fonte_cp, bus.fonte_wb});
   endfunction

   function automatic int strobes();
      return int'(bus.rf_we) + int'(bus.cp_we) + int'(bus.mul_start) +
             int'(bus.hilo_we);
   endfunction

   // One clock: drive inputs just after the falling edge, sample 1 later.
   task automatic apply(input logic rv, input logic [3:0] op, input logic z,
                        input logic md);
      @(negedge clk);
      bus.ri_valid = rv;
      bus.op_code  = op;
      bus.zero     = z;
      bus.mul_done = md;
      #1;
   endtask

   task automatic release_rst();
      @(negedge clk);
      bus.ri_valid = 1'b0;
      bus.mul_done = 1'b0;
      rst = 1'b0;
      #1;
      check("rst_idle", int'({bus.busy, bus.fetch_req}), 0);
      @(negedge clk);
      #1;
      check("rst_fetch", int'({bus.busy, bus.fetch_req}), 3);
      m_err = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.ri_valid = 1'b0;
      bus.op_code  = 4'h0;
      bus.zero     = 1'b0;
      bus.mul_done = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_outs", outs(), 0);
      @(negedge clk);
      #1;
      check("rst_hold", outs(), 0);
      release_rst();
   endtask

   task automatic check_halt_quiet();
      int bad;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         apply(1'b1, 4'($urandom), 1'($urandom), 1'($urandom));
         if (strobes() != 0 || bus.busy || bus.fetch_req) bad++;
      end
      check("halt_quiet", bad, 0);
   endtask

   task automatic run_instr(input logic [3:0] op, input logic zv,
                            input int ri_delay, input int mul_d,
                            output bit halted);
      int    e_rf, e_cp, e_ms, e_hw, e_rf_c, e_cp_c, e_hw_c, e_end, e_fcp, e_fwb;
      bit    e_halt;
      int    n_rf, n_cp, n_ms, n_hw, rf_c, cp_c, ms_c, hw_c, fcp, fwb;
      int    cp_ula, ex_ula, end_c, bad, excl, c;
      bit    done;
      logic  md;
      string t;

      t = $sformatf("op%h", op);

      // Reference: every instruction ends with exactly one cp_we in WB,
      // three cycles after the accepting FETCH cycle (MUL adds its wait).
      e_rf = 0; e_cp = 1; e_ms = 0; e_hw = 0;
      e_rf_c = -1; e_cp_c = 3; e_hw_c = -1; e_end = 4;
      e_fcp = 0; e_fwb = -1; e_halt = 1'b0;
      if (op <= 4'd7) begin
         e_rf = 1; e_rf_c = 3; e_fwb = 0;
      end else if (op == 4'd8) begin
         e_ms = 1;
         if (mul_d <= TO) begin
            e_hw = 1; e_hw_c = 2 + mul_d; e_cp_c = 3 + mul_d; e_end = 4 + mul_d;
         end else begin
            e_cp = 0; e_halt = 1'b1; e_end = 3 + TO; m_err = 1'b1;
         end
      end else if (op == 4'd9 || op == 4'd10) begin
         e_rf = 1; e_rf_c = 3; e_fwb = int'(op) - 8;
      end else if (op == 4'd11) begin
         e_fcp = zv ? 2 : 0;
      end else if (op == 4'd12) begin
         e_fcp = 2;
      end else if (op == 4'd15) begin
         e_cp = 0; e_halt = 1'b1; e_end = 3;
      end else begin
         m_err = 1'b1;
      end

      bad = 0;
      for (int i = 0; i < ri_delay; i++) begin
         apply(1'b0, 4'($urandom), 1'($urandom), 1'b0);
         if (!bus.fetch_req || !bus.busy || strobes() != 0) bad++;
      end
      if (ri_delay > 0) check({t, "_fetch_stall"}, bad, 0);

      n_rf = 0; n_cp = 0; n_ms = 0; n_hw = 0;
      rf_c = -1; cp_c = -1; ms_c = -1; hw_c = -1; fcp = -1; fwb = -1;
      cp_ula = -1; ex_ula = -1; end_c = -1; excl = 0; c = 0; done = 1'b0;
      while (!done) begin
         md = (op == 4'd8) && (c == 2 + mul_d);
         apply(c == 0, (c <= 1) ? op : 4'($urandom), (c == 2) ? zv : ~zv, md);
         if (c > 0 && bus.fetch_req) begin
            end_c = c;
            done  = 1'b1;
         end else if (!bus.busy) begin
            end_c = c;
            done  = 1'b1;
         end else begin
            if (c == 2) ex_ula = int'({bus.ula_op, bus.ula_a, bus.ula_b});
            if (bus.rf_we) begin
               n_rf++; rf_c = c; fwb = int'(bus.fonte_wb);
            end
            if (bus.cp_we) begin
               n_cp++; cp_c = c; fcp = int'(bus.fonte_cp);
               cp_ula = int'({bus.ula_op, bus.ula_a, bus.ula_b});
            end
            if (bus.mul_start) begin
               n_ms++; ms_c = c;
            end
            if (bus.hilo_we) begin
               n_hw++; hw_c = c;
            end
            if (int'(bus.mul_start) + int'(bus.hilo_we) +
                int'(bus.rf_we | bus.cp_we) > 1) excl++;
         end
         c++;
         if (!done && c > 80) begin
            check({t, "_cycle_budget"}, c, e_end);
            done = 1'b1;
         end
      end

      check({t, "_end_cycle"}, end_c, e_end);
      check({t, "_halted"}, int'(bus.busy == 1'b0), int'(e_halt));
      check({t, "_n_rf_we"}, n_rf, e_rf);
      check({t, "_n_cp_we"}, n_cp, e_cp);
      check({t, "_n_mul_start"}, n_ms, e_ms);
      check({t, "_n_hilo_we"}, n_hw, e_hw);
      check({t, "_excl"}, excl, 0);
      if (e_cp != 0) begin
         check({t, "_cp_cycle"}, cp_c, e_cp_c);
         check({t, "_fonte_cp"}, fcp, e_fcp);
         // CP+1: ula_op=ADD(0), ula_a=CP(0), ula_b=const 1(1)
         if (e_fcp == 0) check({t, "_cp_ula"}, cp_ula, 1);
      end
      if (e_rf != 0) begin
         check({t, "_rf_cycle"}, rf_c, e_rf_c);
         check({t, "_fonte_wb"}, fwb, e_fwb);
      end
      if (e_ms != 0) check({t, "_ms_cycle"}, ms_c, 2);
      if (e_hw != 0) check({t, "_hw_cycle"}, hw_c, e_hw_c);
      // EXEC selects {ula_op, ula_a=1, ula_b=(ADDI ? 2 : 0)}
      if (op <= 4'd7)
         check({t, "_exec_ula"}, ex_ula,
               int'(op) * 8 + 4 + ((op == 4'd7) ? 2 : 0));
      check({t, "_err"}, int'(bus.err), int'(m_err));

      halted = e_halt || !bus.busy;
      if (halted) check_halt_quiet();
   endtask

   task automatic mid_mulw_reset();
      apply(1'b1, 4'h8, 1'b0, 1'b0);
      apply(1'b0, 4'h8, 1'b0, 1'b0);
      apply(1'b0, 4'h0, 1'b0, 1'b0);
      check("mid_mul_start", int'(bus.mul_start), 1);
      for (int i = 0; i < 8; i++) apply(1'b0, 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      bus.mul_done = 1'b1;
      #1;
      check("mid_hilo_pre", int'(bus.hilo_we), 1);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_outs", outs(), 0);
      bus.mul_done = 1'b0;
      @(negedge clk);
      #1;
      check("mid_rst_hold", outs(), 0);
      release_rst();
   endtask

   initial begin
      bit          h;
      logic [3:0]  op;
      int          md;

      bus.ri_valid = 1'b0;
      bus.op_code  = 4'h0;
      bus.zero     = 1'b0;
      bus.mul_done = 1'b0;

      do_reset();

      run_instr(4'h0, 1'b0, 0, 0, h);   // ADD, RI already valid
      run_instr(4'h1, 1'b1, 5, 0, h);   // SUB after 5-cycle RI stall
      run_instr(4'h8, 1'b0, 0, 16, h);  // MUL, done after 16 cycles
      run_instr(4'hB, 1'b1, 0, 0, h);   // BEQZ taken
      run_instr(4'hB, 1'b0, 0, 0, h);   // BEQZ not taken
      run_instr(4'hC, 1'b0, 2, 0, h);   // JMP
      run_instr(4'h9, 1'b0, 0, 0, h);   // MFHI
      run_instr(4'hA, 1'b0, 0, 0, h);   // MFLO
      run_instr(4'h7, 1'b0, 1, 0, h);   // ADDI
      run_instr(4'h8, 1'b0, 0, TO, h);  // MUL done in last watchdog cycle
      run_instr(4'hD, 1'b0, 0, 0, h);   // illegal -> err, CP+1
      run_instr(4'h3, 1'b0, 0, 0, h);   // err stays sticky
      do_reset();
      check("err_cleared", int'(bus.err), 0);
      run_instr(4'h8, 1'b0, 0, TO + 1, h);  // watchdog expiry
      if (h) do_reset();
      mid_mulw_reset();
      run_instr(4'h2, 1'b0, 0, 0, h);   // sequencing resumes after reset
      run_instr(4'hF, 1'b0, 0, 0, h);   // HALT
      if (h) do_reset();

      for (int k = 0; k < 60; k++) begin
         op = 4'($urandom_range(0, 15));
         md = ($urandom_range(0, 5) == 0) ? $urandom_range(TO + 1, TO + 8)
                                          : $urandom_range(1, TO);
         run_instr(op, 1'($urandom), $urandom_range(0, 3), md, h);
         if (h) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
